// File: rtl/cascade_feature_sequencer.sv
// Per-window cascade controller: walks stages, streams global feature indices
// through the weight-ROM output register, and collects one verdict per stage.
module cascade_feature_sequencer #(
    parameter int W_ADDR   = 12,
    parameter int N_STAGES = 25,
    parameter int W_STAGE  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               detected,
    output logic               stage_rd_en,
    output logic [W_STAGE-1:0] stage_idx,
    input  logic [W_ADDR-1:0]  stage_last_feat,
    output logic               rom_en,
    output logic [W_ADDR-1:0]  rom_addr,
    output logic               feat_valid,
    input  logic               feat_ready,
    output logic [W_ADDR-1:0]  feat_idx,
    output logic               feat_last,
    input  logic               res_valid,
    input  logic               res_pass
);

    // state       | meaning
    // IDLE        | waiting for start
    // LOAD_STAGE  | stage-table read issued for stage_idx
    // LATCH_STAGE | stage-table data captured into r_last
    // FETCH       | issuing features into the ROM output register
    // WAIT_RES    | last feature handed off, waiting for the verdict
    // DONE        | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_STAGE,
        S_LATCH_STAGE,
        S_FETCH,
        S_WAIT_RES,
        S_DONE
    } state_t;

    localparam logic [W_STAGE-1:0] LP_LAST_STAGE = W_STAGE'(N_STAGES - 1);
    localparam logic [W_ADDR-1:0]  LP_CNT_MAX    = '1;

    state_t              r_state;
    state_t              w_next_state;
    logic [W_ADDR-1:0]   r_cnt;
    logic [W_ADDR-1:0]   r_last;
    logic                r_issued;
    logic [W_STAGE-1:0]  r_stage_idx;
    logic                r_detected;
    logic                r_feat_valid;
    logic [W_ADDR-1:0]   r_feat_idx;
    logic                r_feat_last;
    logic                w_adv;
    logic                w_issue;
    logic                w_cnt_at_last;

    assign w_adv         = !r_feat_valid || feat_ready;
    assign w_cnt_at_last = (r_cnt >= r_last);

    always_comb begin
        w_next_state = r_state;
        stage_rd_en  = 1'b0;
        rom_en       = 1'b0;
        done         = 1'b0;
        w_issue      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_LOAD_STAGE;
            end
            S_LOAD_STAGE: begin
                stage_rd_en  = 1'b1;
                w_next_state = S_LATCH_STAGE;
            end
            S_LATCH_STAGE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_issue = w_adv && !r_issued;
                rom_en  = w_issue;
                if (r_feat_valid && feat_ready && r_feat_last) w_next_state = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    if (!res_pass || r_stage_idx == LP_LAST_STAGE) w_next_state = S_DONE;
                    else                                           w_next_state = S_LOAD_STAGE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last       <= '0;
            r_issued     <= 1'b0;
            r_stage_idx  <= '0;
            r_detected   <= 1'b0;
            r_feat_valid <= 1'b0;
            r_feat_idx   <= '0;
            r_feat_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt       <= '0;
                        r_stage_idx <= '0;
                        r_detected  <= 1'b0;
                    end
                end
                S_LATCH_STAGE: begin
                    r_last   <= stage_last_feat;
                    r_issued <= 1'b0;
                end
                S_FETCH: begin
                    // A stage always issues at least one feature, so last is forced once cnt has passed r_last.
                    if (w_issue) begin
                        r_feat_valid <= 1'b1;
                        r_feat_idx   <= r_cnt;
                        r_feat_last  <= w_cnt_at_last;
                        r_issued     <= w_cnt_at_last;
                        if (r_cnt != LP_CNT_MAX) r_cnt <= r_cnt + 1'b1;
                    end else if (w_adv) begin
                        r_feat_valid <= 1'b0;
                    end
                end
                S_WAIT_RES: begin
                    if (res_valid) begin
                        if (!res_pass)                          r_detected  <= 1'b0;
                        else if (r_stage_idx == LP_LAST_STAGE)  r_detected  <= 1'b1;
                        else                                    r_stage_idx <= r_stage_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign detected   = r_detected;
    assign stage_idx  = r_stage_idx;
    assign rom_addr   = r_cnt;
    assign feat_valid = r_feat_valid;
    assign feat_idx   = r_feat_idx;
    assign feat_last  = r_feat_last;

endmodule

// File: tb/tb_cascade_feature_sequencer.sv
// Bench for cascade_feature_sequencer: vector table, hand-written hazard
// sequences and random windows checked against a feature-list model.
module tb_cascade_feature_sequencer;

    localparam int W_ADDR  = 12;
    localparam int NS      = 2;
    localparam int W_STAGE = 5;
    localparam int BUDGET  = 6000;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy, done, detected, stage_rd_en;
    logic [W_STAGE-1:0] stage_idx;
    logic [W_ADDR-1:0]  stage_last_feat;
    logic               rom_en;
    logic [W_ADDR-1:0]  rom_addr;
    logic               feat_valid;
    logic               feat_ready;
    logic [W_ADDR-1:0]  feat_idx;
    logic               feat_last;
    logic               res_valid, res_pass;

    cascade_feature_sequencer #(.W_ADDR(W_ADDR), .N_STAGES(NS), .W_STAGE(W_STAGE)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .detected(detected),
        .stage_rd_en(stage_rd_en), .stage_idx(stage_idx), .stage_last_feat(stage_last_feat),
        .rom_en(rom_en), .rom_addr(rom_addr), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_idx(feat_idx), .feat_last(feat_last), .res_valid(res_valid), .res_pass(res_pass)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W_ADDR-1:0] tbl [NS];
    logic              pass_tbl [NS];
    logic [15:0]       w_q;

    function automatic logic [15:0] wfun(input logic [W_ADDR-1:0] a);
        return {4'hA, a} ^ 16'h5A3C;
    endfunction

    // Stage-table ROM and weight ROM, both 1-cycle synchronous.
    always @(posedge clk) begin
        if (stage_rd_en && (int'(stage_idx) < NS)) stage_last_feat <= tbl[int'(stage_idx)];
        if (rom_en) w_q <= wfun(rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: each stage emits cnt..max(last,cnt), last flagged; cnt saturates.
    int exp_idx[$];
    bit exp_last[$];
    int exp_stage_reads;
    bit exp_det;

    function automatic void build_model();
        int cnt = 0;
        exp_idx.delete();
        exp_last.delete();
        exp_stage_reads = 0;
        exp_det = 1'b1;
        for (int s = 0; s < NS; s++) begin
            int e;
            e = (int'(tbl[s]) > cnt) ? int'(tbl[s]) : cnt;
            exp_stage_reads++;
            for (int i = cnt; i <= e; i++) begin
                exp_idx.push_back(i);
                exp_last.push_back(i == e);
            end
            cnt = (e + 1 > 4095) ? 4095 : e + 1;
            if (!pass_tbl[s]) begin
                exp_det = 1'b0;
                break;
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_det"}, 32'(detected), 0);
        chk({tag, "_srd"}, 32'(stage_rd_en), 0);
        chk({tag, "_sidx"}, 32'(stage_idx), 0);
        chk({tag, "_romen"}, 32'(rom_en), 0);
        chk({tag, "_romaddr"}, 32'(rom_addr), 0);
        chk({tag, "_fvalid"}, 32'(feat_valid), 0);
        chk({tag, "_fidx"}, 32'(feat_idx), 0);
        chk({tag, "_flast"}, 32'(feat_last), 0);
    endtask

    // mode 0: ready always; 1: random ready; 2: 3-cycle stall at feature 3
    task automatic run_window(input string tag, input int mode, input bit chaos,
                              output bit det_out, output int nfeat_out);
        int got_idx[$];
        bit got_last[$];
        int rom_seq[$];
        int rd_stage[$];
        int cyc = 0, stage_no = 0, vdelay = 0, stall = 0;
        bit fin = 0, awaiting = 0, acc, r;
        bit prev_stall = 0, prev_acc_nl = 0;
        logic [W_ADDR-1:0] prev_idx = '0;
        logic prev_last = 1'b0;
        logic [15:0] prev_wq = '0;
        det_out = 1'b0;
        build_model();
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        start = 1'b1;
        while (!fin && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            res_valid = 1'b0;
            res_pass = 1'b0;
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, 32'(feat_valid), 1);
                chk({tag, "_stall_idx"}, 32'(feat_idx), 32'(prev_idx));
                chk({tag, "_stall_last"}, 32'(feat_last), 32'(prev_last));
                chk({tag, "_stall_wq"}, 32'(w_q), 32'(prev_wq));
            end
            if (prev_acc_nl) begin
                chk({tag, "_thru_valid"}, 32'(feat_valid), 1);
                chk({tag, "_thru_idx"}, 32'(feat_idx), 32'(prev_idx) + 1);
            end
            if (feat_valid) chk({tag, "_wrom"}, 32'(w_q), 32'(wfun(feat_idx)));
            if (stage_rd_en) rd_stage.push_back(int'(stage_idx));
            if (busy) chk({tag, "_det_busy"}, 32'(detected), 0);
            if (done) begin
                chk({tag, "_busy_at_done"}, 32'(busy), 0);
                det_out = detected;
                fin = 1'b1;
            end
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = ($urandom_range(0, 3) != 0);
            else if (feat_valid && feat_idx == 3 && stall < 3) begin
                r = 1'b0;
                stall++;
            end else r = 1'b1;
            feat_ready = r;
            acc = feat_valid && r;
            if (awaiting) begin
                if (vdelay == 0) begin
                    res_valid = 1'b1;
                    res_pass = pass_tbl[stage_no];
                    stage_no++;
                    awaiting = 1'b0;
                end else vdelay--;
            end else if (chaos && $urandom_range(0, 7) == 0) begin
                res_valid = 1'b1;
                res_pass = 1'($urandom_range(0, 1));
            end
            if (chaos && busy && $urandom_range(0, 5) == 0) start = 1'b1;
            if (acc) begin
                got_idx.push_back(int'(feat_idx));
                got_last.push_back(feat_last);
                if (feat_last) begin
                    awaiting = 1'b1;
                    vdelay = (mode == 0) ? 0 : int'($urandom_range(0, 3));
                end
            end
            #1;
            if (rom_en) rom_seq.push_back(int'(rom_addr));
            if (feat_valid && !r) chk({tag, "_stall_romen"}, 32'(rom_en), 0);
            prev_stall  = feat_valid && !r;
            prev_acc_nl = acc && !feat_last;
            prev_idx    = feat_idx;
            prev_last   = feat_last;
            prev_wq     = w_q;
        end
        chk({tag, "_finished"}, 32'(fin), 1);
        if (fin) begin
            @(negedge clk);
            res_valid = 1'b0;
            chk({tag, "_done_pulse"}, 32'(done), 0);
            chk({tag, "_det_hold"}, 32'(detected), 32'(det_out));
        end
        chk({tag, "_det"}, 32'(det_out), 32'(exp_det));
        chk({tag, "_nfeat"}, 32'(got_idx.size()), 32'(exp_idx.size()));
        for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
            chk({tag, "_fidx"}, 32'(got_idx[i]), 32'(exp_idx[i]));
            chk({tag, "_flast"}, 32'(got_last[i]), 32'(exp_last[i]));
        end
        chk({tag, "_nrom"}, 32'(rom_seq.size()), 32'(exp_idx.size()));
        for (int i = 0; i < rom_seq.size() && i < exp_idx.size(); i++)
            chk({tag, "_romaddr"}, 32'(rom_seq[i]), 32'(exp_idx[i]));
        chk({tag, "_nreads"}, 32'(rd_stage.size()), 32'(exp_stage_reads));
        for (int i = 0; i < rd_stage.size(); i++)
            chk({tag, "_rdstage"}, 32'(rd_stage[i]), 32'(i));
        nfeat_out = got_idx.size();
    endtask

    typedef struct {
        int l0;
        int l1;
        bit p0;
        bit p1;
        int mode;
        bit chaos;
        bit edet;
        int nfeat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit det;
        int nf;
        bit found;
        vecs[0] = '{1, 4, 1'b1, 1'b1, 0, 1'b0, 1'b1, 5};
        vecs[1] = '{1, 4, 1'b0, 1'b1, 0, 1'b0, 1'b0, 2};
        vecs[2] = '{1, 4, 1'b1, 1'b1, 2, 1'b0, 1'b1, 5};
        vecs[3] = '{0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 2};
        vecs[4] = '{3, 2, 1'b1, 1'b1, 1, 1'b1, 1'b1, 5};
        vecs[5] = '{2, 6, 1'b1, 1'b0, 1, 1'b1, 1'b0, 7};
        vecs[6] = '{0, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1};
        vecs[7] = '{4095, 4095, 1'b1, 1'b1, 0, 1'b0, 1'b1, 4097};

        rst = 1'b1; start = 1'b0; feat_ready = 1'b0; res_valid = 1'b0; res_pass = 1'b0;
        stage_last_feat = '0; w_q = '0;
        tbl[0] = '0; tbl[1] = '0; pass_tbl[0] = 1'b0; pass_tbl[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            tbl[0] = W_ADDR'(vecs[v].l0);
            tbl[1] = W_ADDR'(vecs[v].l1);
            pass_tbl[0] = vecs[v].p0;
            pass_tbl[1] = vecs[v].p1;
            run_window($sformatf("vec%0d", v), vecs[v].mode, vecs[v].chaos, det, nf);
            chk($sformatf("vec%0d_tbl_det", v), 32'(det), 32'(vecs[v].edet));
            chk($sformatf("vec%0d_tbl_nfeat", v), 32'(nf), 32'(vecs[v].nfeat));
        end

        // Reset in the middle of FETCH, then a clean restart from feature 0.
        tbl[0] = 12'd6; tbl[1] = 12'd9; pass_tbl[0] = 1'b1; pass_tbl[1] = 1'b1;
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            feat_ready = 1'b1;
            if (feat_valid && feat_idx == 2) found = 1'b1;
        end
        chk("midrst_reach", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        run_window("after_rst", 0, 1'b0, det, nf);
        chk("after_rst_det", 32'(det), 1);
        chk("after_rst_nfeat", 32'(nf), 10);

        for (int k = 0; k < 40; k++) begin
            tbl[0] = W_ADDR'($urandom_range(0, 12));
            tbl[1] = W_ADDR'($urandom_range(0, 12));
            pass_tbl[0] = ($urandom_range(0, 3) != 0);
            pass_tbl[1] = ($urandom_range(0, 3) != 0);
            run_window($sformatf("rnd%0d", k), 1, 1'b1, det, nf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cascade_feature_sequencer.md
Name: cascade_feature_sequencer

Overview:
- Per-window controller that walks the cascade classifier stage by stage.
- For each stage it:
  - reads the stage's last-feature index from the stage-table ROM;
  - issues sequential feature addresses to the weight ROMs (weights0/1/2 share one address and enable);
  - streams the feature indices downstream over a valid/ready handshake;
  - waits for the stage verdict, then continues to the next stage or terminates.
- Sits between the window buffer (start) and the feature-evaluation/stage-accumulate datapath.

Parameters:
- W_ADDR, 12, width of feature index / weight ROM address.
- N_STAGES, 25, number of cascade stages.
- W_STAGE, 5, width of stage index (must satisfy 2^W_STAGE >= N_STAGES).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse: new integral window ready.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at end of window.
- detected  out  1  valid with done: all stages passed.
- stage_rd_en  out  1  stage-table ROM read enable.
- stage_idx  out  W_STAGE  stage-table ROM address / current stage.
- stage_last_feat  in  W_ADDR  stage-table data: last feature index of stage, valid 1 cycle after stage_rd_en.
- rom_en  out  1  weight ROM enable; ROM data updates only when high.
- rom_addr  out  W_ADDR  weight ROM address.
- feat_valid  out  1  weight ROM data register holds a valid feature.
- feat_ready  in  1  downstream accepts feature.
- feat_idx  out  W_ADDR  feature index corresponding to current ROM data.
- feat_last  out  1  feature is last of current stage.
- res_valid  in  1  stage verdict strobe.
- res_pass  in  1  stage verdict: 1 = pass.

Behaviour:
- Weight ROMs are synchronous with 1-cycle latency and hold data while rom_en=0. The ROM output register is the feature output register; no extra skid buffer.
- Reset: state=IDLE. busy=0, done=0, detected=0, stage_rd_en=0, stage_idx=0, rom_en=0, rom_addr=0, feat_valid=0, feat_idx=0, feat_last=0. Internal feature counter cnt=0.
- States: IDLE, LOAD_STAGE, LATCH_STAGE, FETCH, WAIT_RES, DONE.
- IDLE:
  - On start: cnt<=0, stage_idx<=0, busy<=1, go to LOAD_STAGE.
  - start while busy is ignored, in every state.
- LOAD_STAGE: stage_rd_en=1 for exactly one cycle, then go to LATCH_STAGE.
- LATCH_STAGE: register stage_last_feat into last_r, then go to FETCH.
- FETCH:
  - Define adv = !feat_valid || feat_ready.
  - While adv and the stage is not fully issued:
    - rom_en=1, rom_addr=cnt;
    - next cycle: feat_valid<=1, feat_idx<=cnt, feat_last<=(cnt>=last_r);
    - cnt<=cnt+1.
  - When adv and nothing is left to issue: rom_en=0, feat_valid<=0.
  - The stage is fully issued once the feature with feat_last=1 has been issued.
  - Each stage always issues at least one feature, even if last_r < cnt.
  - Back-to-back throughput is 1 feature/cycle.
  - feat_valid, feat_idx and feat_last stay stable while feat_valid && !feat_ready.
  - Go to WAIT_RES when the feature with feat_last=1 is accepted (feat_valid && feat_ready).
- cnt behaviour:
  - cnt is not reset between stages: feature indices are global and contiguous across stages.
  - cnt saturates at 2^W_ADDR-1; it does not wrap.
- WAIT_RES: on res_valid:
  - res_pass=0: detected<=0, go to DONE.
  - res_pass=1 and stage_idx==N_STAGES-1: detected<=1, go to DONE.
  - res_pass=1 otherwise: stage_idx<=stage_idx+1, go to LOAD_STAGE.
  - res_valid in any state other than WAIT_RES is ignored.
- DONE:
  - done=1 for one cycle; busy<=0; go to IDLE.
  - detected holds until the next accepted start, which clears it.
- Reset mid-operation: returns to IDLE within 1 cycle with all outputs at reset values. Any in-flight feature is dropped, not delivered.

Test Plan:
- N_STAGES=2, stage table {1,4}, feat_ready=1; start. Expected:
  - features 0,1 stream with feat_last on 1; res_pass=1;
  - features 2,3,4 stream with feat_last on 4; res_pass=1;
  - done=1 with detected=1; busy drops the same cycle done is asserted.
- Same table, stage 0 res_pass=0. Expected: done with detected=0; no stage_rd_en for stage 1; rom_en never issues address 2.
- Backpressure: feat_ready low for 3 cycles while feat_valid=1 at feat_idx=3. Expected: feat_idx, feat_last and ROM data stable; rom_en=0 during the stall; feature 4 follows on the cycle after ready returns.
- Degenerate stage: table {0,0}. Expected: stage 0 issues feature 0 (last); stage 1 issues only feature 1 (last, since last_r<cnt).
- Control hazards:
  - start pulsed while busy is ignored;
  - res_valid pulsed during FETCH is ignored;
  - rst asserted mid-FETCH: next cycle all outputs are 0 and state is IDLE;
  - a following start restarts from feature 0 and stage 0.
